// File: rtl/subbytes_state_seq_if.sv
// Handshake bundle for subbytes_state_seq: upstream state intake and downstream result with fault summary.
interface subbytes_state_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         out_error;
  logic [4:0]   out_err_count;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, out_error, out_err_count
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, out_error, out_err_count
  );
endinterface

// File: rtl/subbytes_state_seq.sv
// Streams a 128-bit AES state byte-by-byte through an external checked S-box and reassembles it.
// Optional per-byte retry on checker errors is compiled in with SUBBYTES_RETRY_EN.
module subbytes_state_seq #(
  parameter int RETRY_MAX = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  subbytes_state_seq_if.slave  bus,
  output logic [7:0]           byte_in,
  input  logic [7:0]           byte_out,
  input  logic                 byte_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [15:0][7:0]  data_r;
  logic [15:0][7:0]  result_r;
  logic [3:0]        idx_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              out_error_r;
  logic [4:0]        err_count_r;
  logic              exhausted_s;

`ifdef SUBBYTES_RETRY_EN
  localparam logic [2:0] RETRY_LIMIT = 3'(RETRY_MAX);
  logic [2:0] retry_r;
  assign exhausted_s = (retry_r >= RETRY_LIMIT);
`else
  assign exhausted_s = 1'b1;
`endif

  assign bus.in_ready      = in_ready_r;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_state     = result_r;
  assign bus.out_error     = out_error_r;
  assign bus.out_err_count = err_count_r;

  // Present the current byte to the S-box only while substituting
  always_comb begin
    byte_in = 8'h00;
    if (state_r == SUB) begin
      byte_in = data_r[idx_r];
    end else begin
      byte_in = 8'h00;
    end
  end

  // Sequencer FSM with registered handshake and fault-summary outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      data_r      <= '0;
      result_r    <= '0;
      idx_r       <= 4'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_error_r <= 1'b0;
      err_count_r <= 5'd0;
`ifdef SUBBYTES_RETRY_EN
      retry_r     <= 3'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            data_r      <= bus.in_state;
            idx_r       <= 4'd0;
            out_error_r <= 1'b0;
            err_count_r <= 5'd0;
            in_ready_r  <= 1'b0;
`ifdef SUBBYTES_RETRY_EN
            retry_r     <= 3'd0;
`endif
            state_r     <= SUB;
          end
        end
        SUB: begin
          // A retried byte is overwritten on its next attempt
          result_r[idx_r] <= byte_out;
          if (byte_error && !exhausted_s) begin
`ifdef SUBBYTES_RETRY_EN
            retry_r <= retry_r + 3'd1;
`endif
          end else begin
`ifdef SUBBYTES_RETRY_EN
            retry_r <= 3'd0;
`endif
            if (byte_error) begin
              out_error_r <= 1'b1;
              err_count_r <= err_count_r + 5'd1;
            end
            if (idx_r == 4'd15) begin
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              idx_r <= idx_r + 4'd1;
            end
          end
        end
        DONE: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subbytes_state_seq.sv
// Randomized self-checking bench for subbytes_state_seq against a behavioural S-box/sequencing model.
// Works with or without SUBBYTES_RETRY_EN defined.
module tb_subbytes_state_seq;

`ifdef SUBBYTES_RETRY_EN
  localparam int MAXR = 1;
`else
  localparam int MAXR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_in;
  logic [7:0] byte_out;
  logic       byte_error;
  logic       err_now = 1'b0;
  logic [7:0] sbox_t [256];

  int tests = 0;
  int fails = 0;
  int last_lat;
  logic [127:0] last_out;
  logic         last_err;
  logic [4:0]   last_cnt;

  subbytes_state_seq_if bus ();

  subbytes_state_seq #(.RETRY_MAX(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .byte_in    (byte_in),
    .byte_out   (byte_out),
    .byte_error (byte_error)
  );

  always #5 clk = ~clk;

  // Byte unit: true S-box, corrupted when the injected checker error is raised
  assign byte_out   = sbox_t[byte_in] ^ (err_now ? 8'hA5 : 8'h00);
  assign byte_error = err_now;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One state through the DUT; the model tracks byte index and attempts per cycle
  task automatic run_txn(input logic [127:0] st, input logic [15:0] tmask, input logic [15:0] smask,
                         input bit pre_rdy, input int delay, input int abort_at);
    int k = 0;
    int a = 0;
    int n = 0;
    int w = 0;
    int exp_cnt = 0;
    bit e;
    logic [127:0] exp_st = '0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("in_ready_timeout", 128'(bus.in_ready), 128'd1);
    bus.in_valid  = 1'b1;
    bus.in_state  = st;
    bus.out_ready = pre_rdy;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_state = {$urandom, $urandom, $urandom, $urandom};
    while (k < 16 && n < 200) begin
      chk("byte_in", 128'(byte_in), 128'(st[8*k +: 8]));
      chk("sub_out_valid", 128'(bus.out_valid), 128'd0);
      chk("sub_in_ready", 128'(bus.in_ready), 128'd0);
      if (abort_at == k && a == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_byte_in", 128'(byte_in), 128'd0);
        chk("rst_out_error", 128'(bus.out_error), 128'd0);
        chk("rst_err_count", 128'(bus.out_err_count), 128'd0);
        chk("rst_out_state", bus.out_state, 128'd0);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        return;
      end
      e = smask[k] || (tmask[k] && a == 0);
      err_now = e;
      if (!e || a >= MAXR) begin
        exp_st[8*k +: 8] = sbox_t[st[8*k +: 8]] ^ (e ? 8'hA5 : 8'h00);
        if (e) exp_cnt++;
        k++;
        a = 0;
      end else begin
        a++;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      err_now = 1'b0;
    end
    last_lat = n + 1;
    chk("out_valid_rise", 128'(bus.out_valid), 128'd1);
    chk("out_state", bus.out_state, exp_st);
    chk("out_error", 128'(bus.out_error), 128'(exp_cnt != 0));
    chk("out_err_count", 128'(bus.out_err_count), 128'(exp_cnt));
    chk("done_in_ready", 128'(bus.in_ready), 128'd0);
    last_out = bus.out_state;
    last_err = bus.out_error;
    last_cnt = bus.out_err_count;
    if (!pre_rdy) begin
      for (int i = 0; i < delay; i++) begin
        @(posedge clk);
        @(negedge clk);
        chk("hold_out_valid", 128'(bus.out_valid), 128'd1);
        chk("hold_out_state", bus.out_state, exp_st);
        chk("hold_in_ready", 128'(bus.in_ready), 128'd0);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_out_valid", 128'(bus.out_valid), 128'd0);
    chk("post_in_ready", 128'(bus.in_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] st;
    logic [15:0]  tm;
    logic [15:0]  sm;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    chk("model_sbox_00", 128'(sbox_t[0]), 128'h63);
    chk("model_sbox_01", 128'(sbox_t[1]), 128'h7c);
    chk("model_sbox_53", 128'(sbox_t[8'h53]), 128'hed);
    chk("model_sbox_ff", 128'(sbox_t[8'hff]), 128'h16);

    repeat (3) @(negedge clk);
    chk("reset_in_ready", 128'(bus.in_ready), 128'd1);
    chk("reset_out_valid", 128'(bus.out_valid), 128'd0);
    chk("reset_out_state", bus.out_state, 128'd0);
    chk("reset_out_error", 128'(bus.out_error), 128'd0);
    chk("reset_err_count", 128'(bus.out_err_count), 128'd0);
    chk("reset_byte_in", 128'(byte_in), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(128'd0, 16'h0, 16'h0, 1'b0, 0, -1);
    chk("zero_state_literal", last_out, {16{8'h63}});
    chk("zero_latency", 128'(last_lat), 128'd17);
    chk("zero_count_literal", 128'(last_cnt), 128'd0);

    run_txn(128'h0f0e0d0c0b0a09080706050403020100, 16'h0, 16'h0, 1'b1, 0, -1);
    chk("seq_state_literal", last_out, 128'h76abd7fe2b670130c56f6bf27b777c63);

    run_txn(128'h0f0e0d0c0b0a09080706050403020100, 16'h0020, 16'h0, 1'b0, 0, -1);
    chk("transient_latency", 128'(last_lat), 128'(17 + MAXR));
    chk("transient_count", 128'(last_cnt), 128'(MAXR == 0 ? 1 : 0));

    run_txn(128'h0f0e0d0c0b0a09080706050403020100, 16'h0, 16'h0008, 1'b0, 0, -1);
    chk("stuck_latency", 128'(last_lat), 128'(17 + MAXR));
    chk("stuck_count_literal", 128'(last_cnt), 128'd1);
    chk("stuck_error_literal", 128'(last_err), 128'd1);

    run_txn({$urandom, $urandom, $urandom, $urandom}, 16'h0, 16'h0, 1'b0, 5, -1);
    run_txn({$urandom, $urandom, $urandom, $urandom}, 16'h0, 16'h0, 1'b0, 0, 8);
    run_txn(128'd0, 16'h0, 16'h0, 1'b0, 1, -1);
    chk("after_reset_literal", last_out, {16{8'h63}});
    run_txn(128'h0f0e0d0c0b0a09080706050403020100, 16'h0, 16'hffff, 1'b0, 0, -1);
    chk("all_stuck_count", 128'(last_cnt), 128'd16);

    for (int t = 0; t < 25; t++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      tm = '0;
      sm = '0;
      for (int b = 0; b < 16; b++) begin
        tm[b] = ($urandom_range(0, 5) == 0);
        sm[b] = ($urandom_range(0, 9) == 0);
      end
      run_txn(st, tm, sm, 1'($urandom_range(0, 1)), $urandom_range(0, 4), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/subbytes_state_seq.md
# subbytes_state_seq

Sequencer wrapping the byte-wide fault-checked S-box unit. It accepts a 128-bit AES state and streams its 16 bytes one per cycle through the external combinational `SubBytes` byte unit, whose substituted byte and parity-check `error` are consumed here. It reassembles the substituted state, retries bytes flagged by the checker, and presents the result with a sticky fault summary to the downstream ShiftRows stage.

## Interface
- `RETRY_MAX`, default 1: extra attempts per byte after a flagged error (1..7); used only when retry is compiled in.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — upstream state valid.
- `in_ready`  out  1  — block can accept a state.
- `in_state`  in  128  — input state; byte k = `in_state[8k+7:8k]`.
- `byte_in`  out  8  — byte driven to the S-box unit.
- `byte_out`  in  8  — substituted byte returned by the unit, same cycle.
- `byte_error`  in  1  — checker syndrome nonzero for the current byte.
- `out_valid`  out  1  — result state valid.
- `out_ready`  in  1  — downstream accepts the result.
- `out_state`  out  128  — substituted state, same byte ordering.
- `out_error`  out  1  — at least one byte failed its final attempt.
- `out_err_count`  out  5  — number of bytes failing their final attempt (0..16).

## Operation
- FSM states: IDLE, SUB, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: register `in_state`, clear the index, retry counter, error flag and count, then go to SUB.
- SUB:
  - `byte_in` = registered byte[idx]. This is combinational from registers.
  - Every cycle, `byte_out` is written into result byte[idx].
  - If `byte_error`=0: idx++ and clear the retry counter.
  - If `byte_error`=1 and retries < `RETRY_MAX`: idx holds and the retry counter increments. The byte is re-presented next cycle and the write is overwritten.
  - If `byte_error`=1 and retries exhausted: set `out_error`, `out_err_count`++, keep the faulty byte, then idx++.
  - After idx 15 completes, go to DONE.
- DONE:
  - `out_valid`=1.
  - `out_state`, `out_error` and `out_err_count` are held stable until `out_valid && out_ready`, then return to IDLE.
- `byte_in`=0 outside SUB.
- No new input is accepted during SUB or DONE; `in_ready`=0.
- Reset mid-operation aborts. All registers return to reset values and the partial result is discarded.
- Reset values:
  - `in_ready`=1 (IDLE) and `out_valid`=0.
  - `out_state`=0, `out_error`=0, `out_err_count`=0.
  - `byte_in`=0.
- `out_err_count` saturates naturally at 16 (5 bits); no wrap is possible.

## Timing
- Acceptance edge = cycle 0. SUB occupies cycles 1..16 with no errors. `out_valid` rises at cycle 17.
- Each retry adds one cycle. Worst case is 16·(RETRY_MAX+1) SUB cycles.
- The byte unit is combinational: `byte_out` and `byte_error` are sampled on the same edge that `byte_in` was presented for.
- Output handshake completes on the edge where `out_valid && out_ready`. `in_ready` rises the following cycle; there is no same-cycle bypass. Minimum period between accepted states is 18 cycles.
- `out_ready` may be held high before `out_valid`; completion then occurs at cycle 17.

## Configuration
- `SUBBYTES_RETRY_EN` defined:
  - Retry logic and the counter are present, as described above.
- Not defined:
  - `RETRY_MAX` is ignored and every flagged byte immediately counts as failed.
  - Latency is fixed at 17 cycles.
  - Retry counter logic is absent.

## Test plan
- All-zero `in_state` → `out_state` = 16×0x63. `out_valid` at cycle 17, `out_error`=0, `out_err_count`=0.
- `in_state` bytes 0x00..0x0f (byte0=0x00) → bytes 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76, with byte0=0x63 at `out_state[7:0]`.
- Retry enabled, `RETRY_MAX`=1, `byte_error` forced for one cycle at idx 5 → `out_valid` at cycle 18, correct state, `out_error`=0, count 0.
- Retry enabled, `RETRY_MAX`=1, `byte_error` stuck high at idx 3 → two attempts, `out_error`=1, `out_err_count`=1, `out_valid` at cycle 18. With retry disabled: count 1, `out_valid` at cycle 17.
- Hold `out_ready`=0 for 5 cycles after `out_valid` → `out_state` stable, `in_ready`=0. Asserting `out_ready` completes the handshake, and `in_ready`=1 the next cycle.
- Assert `rst_n`=0 while idx=8 → `out_valid`=0, `byte_in`=0, error outputs 0. After release, `in_ready`=1 and a new state processes normally.
